led_pattern_seq: RTL and testbench



---
 rtl/led_pattern_seq.sv | 190 +++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// ---------------------------------------------------------------------------
// led_pattern_seq
//
// LED pattern sequencer for the user-LED bank. One free-running prescaler
// paces four selectable patterns: chase up, chase down, bounce and bar fill.
// Tact1 holds the pattern in restart while pressed. Each press of Tact2
// selects the next mode. Both buttons are synchronised and debounced here.
//
// Ports
//   CLK_24MHz  in   system clock; all logic runs on the rising edge
//   RESET_N    in   asynchronous, active-low reset
//   Tact1      in   asynchronous button; held = restart (idle, LEDs off)
//   Tact2      in   asynchronous button; press = next mode
//   USER_LED   out  [N_LED] registered LED drive; LED_ON is the lit level
//   MODE       out  [2] registered current mode
//   TICK       out  one-clock pulse, registered, on each prescaler step
// ---------------------------------------------------------------------------
module led_pattern_seq #(
   parameter int   N_LED   = 8,
   parameter int   W_CNT   = 23,
   parameter int   W_DB    = 16,
   parameter logic TACT_ON = 1'b0,
   parameter logic LED_ON  = 1'b0
) (
   input  logic             CLK_24MHz,
   input  logic             RESET_N,
   input  logic             Tact1,
   input  logic             Tact2,
   output logic [N_LED-1:0] USER_LED,
   output logic [1:0]       MODE,
   output logic             TICK
);

   localparam int               W_POS       = $clog2(N_LED + 1);
   localparam logic [W_POS-1:0] POS_LAST    = W_POS'(N_LED - 1);
   localparam logic [W_POS-1:0] POS_FULL    = W_POS'(N_LED);
   localparam logic [N_LED-1:0] LED_OFF_VEC = {N_LED{~LED_ON}};

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // Button index 0 is Tact1 and index 1 is Tact2.
   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            db_lvl_q, db_lvl_d;
   logic [1:0][W_DB-1:0]  db_cnt_q, db_cnt_d;
   logic                  t2_prev_q, t2_prev_d;
   logic [W_CNT-1:0]      cnt_q, cnt_d;
   logic                  tick_q, tick_d;
   state_t                state_q, state_d;
   logic [W_POS-1:0]      pos_q, pos_d;
   logic                  dir_up_q, dir_up_d;
   logic [1:0]            mode_q, mode_d;
   logic [N_LED-1:0]      led_q, led_d;
   logic [N_LED-1:0]      lit;

   logic held;
   logic t2_event;
   logic step;

   // Synchroniser and debouncer. The counter only runs while the
   // synchronised input disagrees with the debounced level. Any return to
   // agreement clears it, so the input must stay changed for 2^W_DB clocks.
   always_comb begin
      sync1_d  = {Tact2, Tact1};
      sync2_d  = sync1_q;
      db_lvl_d = db_lvl_q;
      db_cnt_d = db_cnt_q;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] == db_lvl_q[b]) begin
            db_cnt_d[b] = '0;
         end else if (db_cnt_q[b] == '1) begin
            db_lvl_d[b] = sync2_q[b];
            db_cnt_d[b] = '0;
         end else begin
            db_cnt_d[b] = db_cnt_q[b] + W_DB'(1);
         end
      end
   end

   // Tact1 has priority, so a Tact2 press during a Tact1 hold is dropped.
   assign held      = (db_lvl_q[0] == TACT_ON);
   assign t2_prev_d = db_lvl_q[1];
   assign t2_event  = (db_lvl_q[1] == TACT_ON) && (t2_prev_q != TACT_ON) && !held;

   // The prescaler restarts from all-ones on every reload. The first step
   // after a reload therefore lands exactly 2^W_CNT clocks later.
   always_comb begin
      cnt_d = cnt_q - W_CNT'(1);
      if (held || t2_event || (cnt_q == '0)) begin
         cnt_d = '1;
      end
   end

   assign step   = (cnt_q == '0) && !held;
   assign tick_d = step;

   // Next-state logic. A Tact2 event beats a coincident step.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      dir_up_d = dir_up_q;
      mode_d   = mode_q;
      if (held) begin
         state_d  = ST_IDLE;
         pos_d    = '0;
         dir_up_d = 1'b1;
      end else if (t2_event) begin
         mode_d   = mode_q + 2'd1;
         state_d  = ST_IDLE;
         pos_d    = '0;
         dir_up_d = 1'b1;
      end else if (step) begin
         if (state_q == ST_IDLE) begin
            state_d  = ST_RUN;
            dir_up_d = 1'b1;
            case (mode_q)
               2'd1:    pos_d = POS_LAST;
               2'd3:    pos_d = W_POS'(1);
               default: pos_d = '0;
            endcase
         end else begin
            case (mode_q)
               2'd0: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + W_POS'(1);
               2'd1: pos_d = (pos_q == '0) ? POS_LAST : pos_q - W_POS'(1);
               2'd2: begin
                  // Turn around on arriving at an end. Each endpoint then
                  // shows for a single step.
                  if (dir_up_q) begin
                     pos_d = pos_q + W_POS'(1);
                     if (pos_d == POS_LAST) dir_up_d = 1'b0;
                  end else begin
                     pos_d = pos_q - W_POS'(1);
                     if (pos_d == '0) dir_up_d = 1'b1;
                  end
               end
               // In bar-fill mode, pos is the lit count: 1..N_LED, then 0.
               default: pos_d = (pos_q == POS_FULL) ? '0 : pos_q + W_POS'(1);
            endcase
         end
      end
   end

   // Output decode from the next state. This keeps USER_LED registered and
   // aligned with TICK.
   always_comb begin
      lit = '0;
      if (state_d == ST_RUN) begin
         for (int i = 0; i < N_LED; i++) begin
            lit[i] = (mode_d == 2'd3) ? (W_POS'(i) < pos_d) : (W_POS'(i) == pos_d);
         end
      end
      led_d = lit ^ LED_OFF_VEC;
   end

   // State register
   always_ff @(posedge CLK_24MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q   <= {2{~TACT_ON}};
         sync2_q   <= {2{~TACT_ON}};
         db_lvl_q  <= {2{~TACT_ON}};
         db_cnt_q  <= '0;
         t2_prev_q <= ~TACT_ON;
         cnt_q     <= '1;
         tick_q    <= 1'b0;
         state_q   <= ST_IDLE;
         pos_q     <= '0;
         dir_up_q  <= 1'b1;
         mode_q    <= 2'd0;
         led_q     <= LED_OFF_VEC;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_lvl_q  <= db_lvl_d;
         db_cnt_q  <= db_cnt_d;
         t2_prev_q <= t2_prev_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         state_q   <= state_d;
         pos_q     <= pos_d;
         dir_up_q  <= dir_up_d;
         mode_q    <= mode_d;
         led_q     <= led_d;
      end
   end

   assign USER_LED = led_q;
   assign MODE     = mode_q;
   assign TICK     = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_seq
//
// Scoreboard bench for led_pattern_seq (N_LED=8, W_CNT=4, W_DB=2, active-low
// buttons and LEDs). The stimulus process keeps a timing model of the design.
// Steps fall every 16 clocks after the latest reload. A button's effect
// lands a fixed number of clocks after it is driven. For every step it
// expects, the stimulus process pushes the expected pattern and mode. The
// pattern comes straight from the pattern rules. A negedge monitor pops an
// entry whenever TICK is seen and compares it against USER_LED and MODE.
// ---------------------------------------------------------------------------
module tb_led_pattern_seq;

   localparam int   NL      = 8;
   localparam int   PERIOD  = 16;
   localparam int   EVT_LAT = 7;
   localparam int   REL_LAT = 6;
   localparam logic TACT_ON = 1'b0;

   logic       CLK_24MHz = 1'b0;
   logic       RESET_N   = 1'b1;
   logic       Tact1     = 1'b1;
   logic       Tact2     = 1'b1;
   logic [7:0] USER_LED;
   logic [1:0] MODE;
   logic       TICK;

   led_pattern_seq #(
      .N_LED   (NL),
      .W_CNT   (4),
      .W_DB    (2),
      .TACT_ON (TACT_ON),
      .LED_ON  (1'b0)
   ) dut (
      .CLK_24MHz (CLK_24MHz),
      .RESET_N   (RESET_N),
      .Tact1     (Tact1),
      .Tact2     (Tact2),
      .USER_LED  (USER_LED),
      .MODE      (MODE),
      .TICK      (TICK)
   );

   always #5 CLK_24MHz = ~CLK_24MHz;

   int cyc = 0;
   always @(posedge CLK_24MHz) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] led;
      logic [1:0] mode;
      int         edge_no;
   } exp_t;

   exp_t sb[$];
   exp_t mon_ex;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   int mdl_r       = 0;
   int mdl_mode    = 0;
   int mdl_steps   = 0;
   bit mdl_held    = 1'b0;
   bit mdl_en      = 1'b0;
   int evt_edge    = -1;
   int t1_on_edge  = -1;
   int t1_off_edge = -1;
   bit t1_now      = 1'b0;

   // Expected active-low LED word for the given 1-based step count
   function automatic logic [7:0] expPattern(int mode, int steps);
      int         n;
      int         idx;
      logic [8:0] fill;
      logic [7:0] lit;
      n = steps - 1;
      case (mode)
         0: lit = 8'd1 << (n % NL);
         1: lit = 8'd1 << (NL - 1 - (n % NL));
         2: begin
            idx = n % (2 * NL - 2);
            if (idx >= NL) idx = 2 * NL - 2 - idx;
            lit = 8'd1 << idx;
         end
         default: begin
            idx  = (n + 1) % (NL + 1);
            fill = (9'd1 << idx) - 9'd1;
            lit  = fill[7:0];
         end
      endcase
      return ~lit;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
   endtask

   // Advance the model to the clock edge numbered e
   task automatic modelEdge(input int e);
      exp_t ex;
      bit   is_step;
      if (e == t1_on_edge) begin
         mdl_held  = 1'b1;
         mdl_steps = 0;
         return;
      end
      if (mdl_held) begin
         if (e == t1_off_edge) begin
            mdl_held = 1'b0;
            mdl_r    = e;
         end
         return;
      end
      is_step = (e > mdl_r) && (((e - mdl_r) % PERIOD) == 0);
      if (e == evt_edge) begin
         mdl_mode  = (mdl_mode + 1) % 4;
         mdl_steps = 0;
         mdl_r     = e;
         if (is_step) begin
            ex.led = 8'hFF; ex.mode = 2'(mdl_mode); ex.edge_no = e;
            sb.push_back(ex);
         end
      end else if (is_step) begin
         mdl_steps++;
         ex.led = expPattern(mdl_mode, mdl_steps); ex.mode = 2'(mdl_mode); ex.edge_no = e;
         sb.push_back(ex);
      end
   endtask

   task automatic tickClk(input int n);
      repeat (n) begin
         @(posedge CLK_24MHz);
         #1;
         if (mdl_en) modelEdge(cyc);
      end
   endtask

   task automatic applyStimulus(input bit t1_press, input bit t2_press);
      t1_now = t1_press;
      Tact1  = t1_press ? TACT_ON : ~TACT_ON;
      Tact2  = t2_press ? TACT_ON : ~TACT_ON;
   endtask

   task automatic doReset();
      mdl_en  = 1'b0;
      sb.delete();
      applyStimulus(1'b0, 1'b0);
      RESET_N = 1'b0;
      #1;
      checkOutput("reset_led", USER_LED, 8'hFF);
      checkOutput("reset_mode", MODE, 0);
      checkOutput("reset_tick", TICK, 0);
      repeat (3) @(posedge CLK_24MHz);
      #1;
      RESET_N     = 1'b1;
      mdl_r       = cyc;
      mdl_mode    = 0;
      mdl_steps   = 0;
      mdl_held    = 1'b0;
      evt_edge    = -1;
      t1_on_edge  = -1;
      t1_off_edge = -1;
      mdl_en      = 1'b1;
   endtask

   task automatic pressTact2(input int len, input bit expect_evt);
      int c;
      int old_mode;
      old_mode = mdl_mode;
      applyStimulus(t1_now, 1'b1);
      c = cyc;
      if (expect_evt) evt_edge = c + EVT_LAT;
      for (int i = 1; i <= len + 10; i++) begin
         tickClk(1);
         if (i == len) applyStimulus(t1_now, 1'b0);
         if (expect_evt && i == EVT_LAT - 1) checkOutput("mode_before_event", MODE, old_mode);
         if (expect_evt && i == EVT_LAT) begin
            checkOutput("mode_after_event", MODE, mdl_mode);
            checkOutput("led_after_event", USER_LED, 8'hFF);
         end
      end
   endtask

   task automatic pressTact1Hold();
      int c;
      applyStimulus(1'b1, 1'b0);
      c = cyc;
      t1_on_edge = c + EVT_LAT;
      tickClk(EVT_LAT);
      checkOutput("hold_led", USER_LED, 8'hFF);
      checkOutput("hold_mode", MODE, mdl_mode);
      tickClk($urandom_range(3, 10));
      pressTact2(10, 1'b0);
      checkOutput("hold_mode_after_t2", MODE, mdl_mode);
      checkOutput("hold_led_after_t2", USER_LED, 8'hFF);
      tickClk($urandom_range(5, 15));
      checkOutput("hold_tick_low", TICK, 0);
      applyStimulus(1'b0, 1'b0);
      c = cyc;
      t1_off_edge = c + REL_LAT;
      tickClk(REL_LAT + PERIOD - 1);
      checkOutput("release_led_idle", USER_LED, 8'hFF);
   endtask

   // Scoreboard monitor
   always @(negedge CLK_24MHz) begin
      if (mdl_en) begin
         while (sb.size() > 0 && sb[0].edge_no < cyc) begin
            n_checks++;
            $display("[TB] FAIL tick_missing: no TICK at cycle %0d, expected one", sb[0].edge_no);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].edge_no == cyc) begin
            mon_ex = sb.pop_front();
            checkOutput("tick_present", TICK, 1);
            checkOutput("tick_led", USER_LED, mon_ex.led);
            checkOutput("tick_mode", MODE, mon_ex.mode);
         end else if (TICK) begin
            n_checks++;
            $display("[TB] FAIL tick_unexpected: TICK got 1, expected 0 (cycle %0d)", cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: run got no end, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int d;
      #2;
      $display("[TB] reset, then run mode 0");
      doReset();
      tickClk(PERIOD - 1);
      checkOutput("idle_before_first_tick", USER_LED, 8'hFF);
      checkOutput("no_tick_before_first", TICK, 0);
      tickClk(PERIOD * 9 + $urandom_range(0, 15));

      $display("[TB] Tact2 glitches");
      repeat (2) pressTact2($urandom_range(1, 3), 1'b0);
      tickClk(PERIOD * 2);

      $display("[TB] mode 1");
      pressTact2(10, 1'b1);
      tickClk(PERIOD * 10 + $urandom_range(0, 15));

      $display("[TB] mode 2");
      pressTact2($urandom_range(5, 12), 1'b1);
      tickClk(PERIOD * 16 + $urandom_range(0, 15));

      $display("[TB] mode 3");
      pressTact2($urandom_range(5, 12), 1'b1);
      tickClk(PERIOD * 11 + $urandom_range(0, 15));

      $display("[TB] Tact2 event coincident with a step");
      d = cyc + EVT_LAT - mdl_r;
      tickClk((PERIOD - (d % PERIOD)) % PERIOD);
      pressTact2($urandom_range(5, 12), 1'b1);
      tickClk(PERIOD * 4);

      $display("[TB] Tact1 hold mid-pattern");
      tickClk($urandom_range(0, 15));
      pressTact1Hold();
      tickClk(PERIOD * 4 + $urandom_range(0, 15));

      $display("[TB] reset mid-pattern");
      doReset();
      tickClk(PERIOD * 3 + 2);
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
